// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and width helpers for the FIFO write-side arbiter
package sync_fifo_pkg;

   // Arbiter FSM: IDLE waits for any request, BUSY owns the FIFO write port
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Default sizing, mirrored by the top-level parameter defaults
   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 16;
   localparam int BURST_DEF = 4;

   // Grant index width for a given producer count
   function automatic int id_width(input int nreq);
      return $clog2(nreq);
   endfunction

   // Beat counter width; one spare bit so Burst itself is representable
   function automatic int cnt_width(input int burst);
      return $clog2(burst) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_if.sv
// rtl/sync_fifo_wr_arbiter_if.sv - producer and FIFO write-port bundle for the arbiter
interface sync_fifo_wr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int Width = 16
);
   localparam int ID_W = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*Width-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_full;
   logic                  fifo_w_enb;
   logic [Width-1:0]      fifo_din;
   logic                  grant_valid;
   logic [ID_W-1:0]       grant_id;

   // Producers and the FIFO flag source drive the inputs
   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_w_enb, fifo_din, grant_valid, grant_id
   );

   // The arbiter itself
   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_w_enb, fifo_din, grant_valid, grant_id
   );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first request after last index
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Scan offsets from farthest (last itself) down to nearest so the nearest hit wins
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % N);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// rtl/sync_fifo_wr_arbiter.sv - round-robin burst arbiter in front of a sync_fifo write port
module sync_fifo_wr_arbiter
   import sync_fifo_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int Width = WIDTH_DEF,
   parameter int Burst = BURST_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   sync_fifo_wr_arbiter_if.slave   bus
);

   localparam int ID_W  = id_width(NREQ);
   localparam int CNT_W = cnt_width(Burst);

   arb_state_t       state;
   logic [ID_W-1:0]  gnt;
   logic [ID_W-1:0]  last_gnt;
   logic [CNT_W-1:0] beat_cnt;

   logic             busy;
   logic             cur_valid;
   logic             xfer;
   logic             rel;
   logic [ID_W-1:0]  pick_last;
   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;

   // While busy the scan starts after the current grant, so a release picks
   // the next owner in the same cycle and no bubble appears between grants
   assign busy      = (state == BUSY);
   assign pick_last = busy ? gnt : last_gnt;
   assign cur_valid = bus.req_valid[gnt];
   assign xfer      = busy && cur_valid && !bus.fifo_full;
   assign rel       = busy && ((xfer && (beat_cnt == CNT_W'(Burst - 1))) || !cur_valid);

   rr_pick #(
      .N  (NREQ),
      .IW (ID_W)
   ) u_pick (
      .req   (bus.req_valid),
      .last  (pick_last),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Steer the granted producer onto the FIFO write port; everything idles at zero
   always_comb begin
      bus.req_ready   = '0;
      bus.fifo_w_enb  = xfer;
      bus.fifo_din    = '0;
      bus.grant_valid = busy;
      bus.grant_id    = '0;
      if (busy) begin
         bus.req_ready[gnt] = !bus.fifo_full;
         bus.fifo_din       = bus.req_data[int'(gnt)*Width +: Width];
         bus.grant_id       = gnt;
      end
   end

   // Grant FSM: arbitrate from IDLE, count beats and rotate while BUSY
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         gnt      <= '0;
         last_gnt <= ID_W'(NREQ - 1);
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  gnt      <= pick_idx;
                  beat_cnt <= '0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (rel) begin
                  last_gnt <= gnt;
                  if (pick_found) begin
                     gnt      <= pick_idx;
                     beat_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb/tb_sync_fifo_wr_arbiter.sv - scoreboard bench for the FIFO write-side arbiter
module tb_sync_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int W     = 16;
   localparam int BURST = 4;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] data;
      logic [31:0]  cyc;
   } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sync_fifo_wr_arbiter_if #(.NREQ(NREQ), .Width(W)) ifc ();

   sync_fifo_wr_arbiter #(.NREQ(NREQ), .Width(W), .Burst(BURST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int gv_low = 0;

   logic [W-1:0] prod_q [NREQ][$];
   logic [W-1:0] fifo_q [$];
   logic [W-1:0] popped_q [$];
   beat_t        exp_q [$];
   beat_t        obs_q [$];
   bit           auto_drain = 1'b0;
   bit           pop_req = 1'b0;

   logic [NREQ-1:0] s_hs, s_ready;
   logic            s_wr, s_gv;
   logic [W-1:0]    s_din;
   logic [1:0]      s_id;

   task automatic drive_inputs();
      for (int i = 0; i < NREQ; i++) begin
         ifc.req_valid[i]       = (prod_q[i].size() > 0);
         ifc.req_data[i*W +: W] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
      end
      ifc.fifo_full = (fifo_q.size() >= DEPTH);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      s_ready = ifc.req_ready;
      s_hs    = ifc.req_valid & ifc.req_ready;
      s_wr    = ifc.fifo_w_enb;
      s_din   = ifc.fifo_din;
      s_id    = ifc.grant_id;
      s_gv    = ifc.grant_valid;
      if (!s_gv) gv_low++;
      if (s_wr) obs_q.push_back('{id: s_id, data: s_din, cyc: 32'(cyc)});
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
         if (s_hs[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
      if (s_wr) fifo_q.push_back(s_din);
      if ((auto_drain || pop_req) && fifo_q.size() > 0) begin
         popped_q.push_back(fifo_q.pop_front());
         pop_req = 1'b0;
      end
      drive_inputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) prod_q[i].delete();
      fifo_q.delete(); popped_q.delete(); exp_q.delete(); obs_q.delete();
      auto_drain = 1'b1;
      pop_req = 1'b0;
      drive_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic push_beat(input int id, input logic [W-1:0] d);
      prod_q[id].push_back(d);
      exp_q.push_back('{id: 2'(id), data: d, cyc: 32'd0});
   endtask

   task automatic run_idle(input string name, input int max);
      int n = 0;
      while (n < max && (ifc.grant_valid || prod_q[0].size() > 0 || prod_q[1].size() > 0 ||
                         prod_q[2].size() > 0 || prod_q[3].size() > 0)) begin
         tick();
         n++;
      end
      checks++;
      if (n >= max) begin
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
         errors++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ifc.grant_valid !== 1'b0 || ifc.fifo_w_enb !== 1'b0) begin
         $display("FAIL reset_ctrl: grant_valid=%b w_enb=%b, required 0 0", ifc.grant_valid, ifc.fifo_w_enb);
         errors++;
      end
      checks++;
      if (ifc.req_ready !== 4'b0 || ifc.grant_id !== 2'd0 || ifc.fifo_din !== 16'h0) begin
         $display("FAIL reset_out: ready=%b id=%0d din=%h, required 0 0 0", ifc.req_ready, ifc.grant_id, ifc.fifo_din);
         errors++;
      end
   endtask

   task automatic test_single();
      int c0;
      do_reset();
      for (int k = 0; k < 3; k++) push_beat(0, 16'hA000 + 16'(k));
      drive_inputs();
      c0 = cyc;
      tick();
      checks++;
      if (s_gv !== 1'b0 || s_wr !== 1'b0) begin
         $display("FAIL single_latency: grant_valid=%b w_enb=%b in arbitration cycle, required 0 0", s_gv, s_wr);
         errors++;
      end
      run_idle("single", 20);
      for (int n = 0; n < obs_q.size(); n++) begin
         checks++;
         if (obs_q[n].cyc !== 32'(c0 + 2 + n)) begin
            $display("FAIL single_cycle: beat %0d at cycle %0d, required %0d", n, obs_q[n].cyc, c0 + 2 + n);
            errors++;
         end
      end
      while (exp_q.size() > 0) begin
         beat_t e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0 || popped_q.size() == 0) begin
            $display("FAIL single_missing: no write for %h, required one", e.data);
            errors++;
         end else begin
            beat_t o = obs_q.pop_front();
            logic [W-1:0] dout = popped_q.pop_front();
            if (o.id !== e.id || o.data !== e.data || dout !== e.data) begin
               $display("FAIL single_data: id=%0d din=%h dout=%h, required id=%0d %h", o.id, o.data, dout, e.id, e.data);
               errors++;
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         $display("FAIL single_extra: %0d extra writes, required 0", obs_q.size());
         errors++;
      end
   endtask

   task automatic test_round_robin();
      int c0;
      do_reset();
      for (int i = 0; i < NREQ; i++)
         for (int k = 0; k < BURST; k++) push_beat(i, 16'h1000 * 16'(i + 1) + 16'(k));
      drive_inputs();
      c0 = cyc;
      run_idle("rr", 60);
      checks++;
      if (obs_q.size() != 16) begin
         $display("FAIL rr_count: %0d writes, required 16", obs_q.size());
         errors++;
      end
      for (int n = 0; n < obs_q.size(); n++) begin
         checks++;
         if (obs_q[n].cyc !== 32'(c0 + 2 + n)) begin
            $display("FAIL rr_bubble: write %0d at cycle %0d, required %0d", n, obs_q[n].cyc, c0 + 2 + n);
            errors++;
         end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         beat_t e = exp_q.pop_front();
         beat_t o = obs_q.pop_front();
         checks++;
         if (o.id !== e.id || o.data !== e.data) begin
            $display("FAIL rr_order: id=%0d data=%h, required id=%0d data=%h", o.id, o.data, e.id, e.data);
            errors++;
         end
      end
   endtask

   task automatic test_rearm();
      int c0;
      do_reset();
      for (int k = 0; k < 6; k++) push_beat(2, 16'h2200 + 16'(k));
      drive_inputs();
      c0 = cyc;
      run_idle("rearm", 30);
      checks++;
      if (obs_q.size() != 6) begin
         $display("FAIL rearm_count: %0d writes, required 6", obs_q.size());
         errors++;
      end
      for (int n = 0; n < obs_q.size(); n++) begin
         checks++;
         if (obs_q[n].cyc !== 32'(c0 + 2 + n) || obs_q[n].id !== 2'd2 ||
             obs_q[n].data !== 16'h2200 + 16'(n)) begin
            $display("FAIL rearm_beat: beat %0d cyc=%0d id=%0d data=%h, required cyc=%0d id=2 data=%h",
                     n, obs_q[n].cyc, obs_q[n].id, obs_q[n].data, c0 + 2 + n, 16'h2200 + 16'(n));
            errors++;
         end
      end
      checks++;
      if (ifc.grant_valid !== 1'b0) begin
         $display("FAIL rearm_idle: grant_valid=%b after drain, required 0", ifc.grant_valid);
         errors++;
      end
   endtask

   task automatic test_full();
      do_reset();
      auto_drain = 1'b0;
      for (int k = 0; k < 10; k++) push_beat(1, 16'h3100 + 16'(k));
      drive_inputs();
      repeat (9) tick();
      checks++;
      if (obs_q.size() != DEPTH || ifc.fifo_full !== 1'b1) begin
         $display("FAIL full_fill: %0d writes full=%b, required %0d 1", obs_q.size(), ifc.fifo_full, DEPTH);
         errors++;
      end
      repeat (3) begin
         tick();
         checks++;
         if (s_wr !== 1'b0 || s_ready[1] !== 1'b0 || s_id !== 2'd1 || s_gv !== 1'b1) begin
            $display("FAIL full_stall: w_enb=%b ready1=%b id=%0d gv=%b, required 0 0 1 1", s_wr, s_ready[1], s_id, s_gv);
            errors++;
         end
      end
      pop_req = 1'b1;
      tick();
      tick();
      checks++;
      if (s_wr !== 1'b1 || s_din !== 16'h3108) begin
         $display("FAIL full_one: w_enb=%b din=%h after pop, required 1 3108", s_wr, s_din);
         errors++;
      end
      tick();
      checks++;
      if (s_wr !== 1'b0 || obs_q.size() != DEPTH + 1) begin
         $display("FAIL full_restall: w_enb=%b writes=%0d, required 0 %0d", s_wr, obs_q.size(), DEPTH + 1);
         errors++;
      end
      auto_drain = 1'b1;
      run_idle("full", 40);
      while (exp_q.size() > 0) begin
         beat_t e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            $display("FAIL full_missing: no write for %h, required one", e.data);
            errors++;
         end else begin
            beat_t o = obs_q.pop_front();
            if (o.id !== e.id || o.data !== e.data) begin
               $display("FAIL full_order: id=%0d data=%h, required id=%0d data=%h", o.id, o.data, e.id, e.data);
               errors++;
            end
         end
      end
   endtask

   task automatic test_drop();
      int n = 0;
      do_reset();
      push_beat(3, 16'h4300);
      push_beat(3, 16'h4301);
      drive_inputs();
      tick();
      for (int k = 0; k < 3; k++) push_beat(0, 16'h4000 + 16'(k));
      drive_inputs();
      gv_low = 0;
      while (obs_q.size() < 5 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (obs_q.size() != 5 || gv_low != 0) begin
         $display("FAIL drop_gap: writes=%0d idle_cycles=%0d, required 5 0", obs_q.size(), gv_low);
         errors++;
      end else begin
         checks++;
         if (obs_q[2].cyc !== obs_q[1].cyc + 2) begin
            $display("FAIL drop_switch: p0 first write at %0d, required %0d", obs_q[2].cyc, obs_q[1].cyc + 2);
            errors++;
         end
      end
      run_idle("drop", 20);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         beat_t e = exp_q.pop_front();
         beat_t o = obs_q.pop_front();
         checks++;
         if (o.id !== e.id || o.data !== e.data) begin
            $display("FAIL drop_order: id=%0d data=%h, required id=%0d data=%h", o.id, o.data, e.id, e.data);
            errors++;
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 4; k++) prod_q[1].push_back(16'h5100 + 16'(k));
      drive_inputs();
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ifc.req_ready !== 4'b0 || ifc.grant_valid !== 1'b0 || ifc.fifo_w_enb !== 1'b0) begin
         $display("FAIL midrst_out: ready=%b gv=%b w_enb=%b, required 0 0 0", ifc.req_ready, ifc.grant_valid, ifc.fifo_w_enb);
         errors++;
      end
      checks++;
      if (obs_q.size() != 1 || obs_q[0].data !== 16'h5100) begin
         $display("FAIL midrst_kept: writes=%0d, required 1 beat 5100", obs_q.size());
         errors++;
      end
      prod_q[1].delete();
      obs_q.delete();
      drive_inputs();
      @(posedge clk);
      #1 reset = 1'b0;
      push_beat(0, 16'h5000);
      push_beat(2, 16'h5200);
      drive_inputs();
      run_idle("midrst", 20);
      while (exp_q.size() > 0) begin
         beat_t e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            $display("FAIL midrst_missing: no write for %h, required one", e.data);
            errors++;
         end else begin
            beat_t o = obs_q.pop_front();
            if (o.id !== e.id || o.data !== e.data) begin
               $display("FAIL midrst_order: id=%0d data=%h, required id=%0d data=%h", o.id, o.data, e.id, e.data);
               errors++;
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_rearm();
      test_full();
      test_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
Name: sync_fifo_wr_arbiter

Overview:
Round-robin burst arbiter that shares the write port of one sync_fifo between NREQ independent producers. Each producer uses a valid/ready handshake. The arbiter drives the FIFO's w_enb/din combinationally from the granted producer and honours the FIFO's full flag. Grants are held for up to Burst beats, so short bursts from one source stay contiguous in the FIFO. Sits directly in front of sync_fifo; the read side is untouched.

Parameters:
NREQ, 4, number of producers (2..8)
Width, 16, data width; must equal the FIFO Width
Burst, 4, maximum beats per grant before rotation (1..16)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-producer data valid
req_data  in  NREQ*Width  producer i occupies bits [i*Width +: Width]
req_ready  out  NREQ  per-producer accept; a beat transfers when req_valid[i] && req_ready[i] at a rising edge
fifo_full  in  1  full flag from sync_fifo
fifo_w_enb  out  1  to sync_fifo w_enb
fifo_din  out  Width  to sync_fifo din
grant_valid  out  1  a grant is active (state BUSY)
grant_id  out  $clog2(NREQ)  index of the granted producer; meaningful only when grant_valid=1

Behaviour:
- States: IDLE, BUSY. Registers: state, gnt (grant index), last_gnt, beat_cnt ($clog2(Burst)+1 bits).
- Reset (async): state=IDLE, gnt=0, last_gnt=NREQ-1 (producer 0 has first priority), beat_cnt=0. Outputs: req_ready=0, fifo_w_enb=0, grant_valid=0, grant_id=0. fifo_din is don't-care but driven as 0 when not BUSY.
- Pick function: first i with req_valid[i]=1, scanning from (last_gnt+1) mod NREQ upward with wrap.
- IDLE: if any req_valid, then next gnt=pick, state->BUSY, beat_cnt=0. One cycle of arbitration latency from IDLE; no transfer happens in IDLE.
- BUSY, combinational outputs:
  - req_ready[gnt] = !fifo_full; all other req_ready = 0.
  - fifo_w_enb = req_valid[gnt] && !fifo_full.
  - fifo_din = req_data[gnt].
  - grant_id = gnt; grant_valid = 1.
- Transfer (xfer) = fifo_w_enb. On xfer, beat_cnt += 1.
- Release condition (BUSY):
  - (a) xfer && beat_cnt==Burst-1, or
  - (b) req_valid[gnt]==0 (producer idle; no transfer this cycle).
- On release: last_gnt=gnt. If any req_valid (excluding gnt in case (b)), load gnt=pick computed with last_gnt=gnt, beat_cnt=0, and stay in BUSY, giving back-to-back grants with no bubble. Otherwise state->IDLE.
- Case (a) with only gnt still valid: gnt is re-granted (pick wraps to itself) and beat_cnt restarts at 0.
- fifo_full in BUSY: no transfer, beat_cnt holds, grant held; no timeout and no release on full alone.
- A producer deasserting valid mid-burst (case b) loses the grant. Its next beat re-arbitrates normally.
- Producers must hold req_data stable while req_valid && !req_ready. The arbiter never drops or duplicates a beat.
- Reset mid-burst: grant dropped immediately. Beats already written stay in the FIFO; no partial-beat state survives.
- Ordering: beats from one producer reach the FIFO in issue order. Interleaving across producers happens only at grant boundaries.

Decomposition:
- Shared package sync_fifo_pkg: state enum (IDLE, BUSY), localparam ID_W=$clog2(NREQ), CNT_W=$clog2(Burst)+1.
- One combinational sub-module rr_pick (inputs: req vector, last index; outputs: found flag, index). It is reusable for a future read-side scheduler.

Test Plan:
- Reset, then req_valid=4'b0001 with data 0xA000..0xA002 -> grant_valid rises 1 cycle later, grant_id=0, 3 back-to-back fifo_w_enb pulses, FIFO dout sequence A000, A001, A002.
- req_valid=4'b1111 held, each producer streaming, Burst=4 -> grant_id sequence 0,0,0,0,1,1,1,1,2,...,3,0; 16 writes in 16 consecutive cycles after the first grant; no bubble between grants.
- Producer 2 alone, 6 beats, Burst=4 -> 4 beats, then re-grant to 2 with beat_cnt reset, then 2 beats, then IDLE.
- Fill the FIFO (8 entries, no reads) while producer 1 is granted -> fifo_w_enb=0 and req_ready[1]=0 while full, grant_id stays 1. Pop one entry -> exactly one transfer, then stall again.
- Producer 3 granted, drops req_valid after 2 beats while producer 0 is valid -> next cycle grant_id=0, no gap cycle.
- Assert reset during beat 2 of a burst -> req_ready=0, grant_valid=0 immediately. After release, request from producer 0 wins first regardless of the prior grant.
